// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel clock gating controller.
// Each channel runs an OFF/WAKE/ON/IDLE state machine from a registered copy of
// its REQ input. A negative-level latch drives a glitch-free AND gate per channel.
// The latch is enabled by CH_ON or by TEST_EN.
// Optional feature (define CLK_GATE_STAT_EN): adds the STAT_CLR input and the
// GATED_CYC_CNT output. GATED_CYC_CNT is a saturating count of cycles in which
// at least one channel is off.
`timescale 1ns/1ps

module clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_DLY = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IDLE_W-1:0] IDLE_THR,
    input  logic              TEST_EN,
    input  logic [NUM_CH-1:0] REQ,
    output logic [NUM_CH-1:0] ACK,
    output logic [NUM_CH-1:0] CH_ON,
    output logic [NUM_CH-1:0] GATED_CLK
`ifdef CLK_GATE_STAT_EN
    ,
    input  logic              STAT_CLR,
    output logic [15:0]       GATED_CYC_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    // Terminal value of the wake counter; WAKE therefore lasts WAKE_DLY cycles.
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_DLY - 1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            state_reg;
            logic              req_reg;
            logic [3:0]        wake_cnt_reg;
            logic [IDLE_W-1:0] idle_cnt_reg;
            logic              ch_on_reg;
            logic              ack_reg;
            logic              en_latch;

            // Channel FSM; REQ is registered first so the FSM sees it one edge later.
            // CH_ON and ACK are registered alongside the state.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    state_reg    <= ST_OFF;
                    req_reg      <= 1'b0;
                    wake_cnt_reg <= '0;
                    idle_cnt_reg <= '0;
                    ch_on_reg    <= 1'b0;
                    ack_reg      <= 1'b0;
                end else begin
                    req_reg <= REQ[gi];
                    case (state_reg)
                        ST_OFF: begin
                            if (req_reg) begin
                                state_reg    <= ST_WAKE;
                                wake_cnt_reg <= '0;
                                ch_on_reg    <= 1'b1;
                            end
                        end
                        ST_WAKE: begin
                            if (!req_reg) begin
                                state_reg <= ST_OFF;
                                ch_on_reg <= 1'b0;
                            end else begin
                                wake_cnt_reg <= wake_cnt_reg + 4'd1;
                                if (wake_cnt_reg == WAKE_LAST) begin
                                    state_reg <= ST_ON;
                                    ack_reg   <= 1'b1;
                                end
                            end
                        end
                        ST_ON: begin
                            if (!req_reg) begin
                                state_reg    <= ST_IDLE;
                                idle_cnt_reg <= '0;
                            end
                        end
                        ST_IDLE: begin
                            if (req_reg) begin
                                state_reg <= ST_ON;
                            end else if (idle_cnt_reg == IDLE_THR) begin
                                state_reg <= ST_OFF;
                                ch_on_reg <= 1'b0;
                                ack_reg   <= 1'b0;
                            end else begin
                                idle_cnt_reg <= idle_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= ST_OFF;
                            ch_on_reg <= 1'b0;
                            ack_reg   <= 1'b0;
                        end
                    endcase
                end
            end

            // Enable latch is open while CLK is low, so the enable never changes during a high phase.
            // Reset clears it immediately so the gated clock stops at once.
            always_latch begin
                if (!RST) begin
                    en_latch <= 1'b0;
                end else if (!CLK) begin
                    en_latch <= ch_on_reg | TEST_EN;
                end
            end

            assign GATED_CLK[gi] = CLK & en_latch;
            assign CH_ON[gi]     = ch_on_reg;
            assign ACK[gi]       = ack_reg;
        end
    endgenerate

`ifdef CLK_GATE_STAT_EN
    logic        any_off;
    logic [15:0] gated_cyc_cnt_reg;

    assign any_off       = ~&CH_ON;
    assign GATED_CYC_CNT = gated_cyc_cnt_reg;

    // Saturating count of cycles with at least one channel off; clear wins over increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gated_cyc_cnt_reg <= '0;
        end else if (STAT_CLR) begin
            gated_cyc_cnt_reg <= '0;
        end else if (any_off && (gated_cyc_cnt_reg != 16'hFFFF)) begin
            gated_cyc_cnt_reg <= gated_cyc_cnt_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: scoreboard bench for clk_gate_ctrl (defaults NUM_CH=4, WAKE_DLY=2).
// Expected values are queued with a target cycle when stimulus is driven.
// Each expected value is compared on the falling edge of that cycle.
// cyc counts CLK rising edges. pulse_cnt[i] counts rising edges of GATED_CLK[i].
`timescale 1ns/1ps

module tb_clk_gate_ctrl;

    logic       CLK;
    logic       RST;
    logic [3:0] IDLE_THR;
    logic       TEST_EN;
    logic [3:0] REQ;
    logic [3:0] ACK;
    logic [3:0] CH_ON;
    logic [3:0] GATED_CLK;
`ifdef CLK_GATE_STAT_EN
    logic       STAT_CLR;
    logic [15:0] GATED_CYC_CNT;
`endif

    clk_gate_ctrl #(.NUM_CH(4), .IDLE_W(4), .WAKE_DLY(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IDLE_THR      (IDLE_THR),
        .TEST_EN       (TEST_EN),
        .REQ           (REQ),
        .ACK           (ACK),
        .CH_ON         (CH_ON),
        .GATED_CLK     (GATED_CLK)
`ifdef CLK_GATE_STAT_EN
        ,
        .STAT_CLR      (STAT_CLR),
        .GATED_CYC_CNT (GATED_CYC_CNT)
`endif
    );

    typedef struct {
        int    cyc;
        string tag;
        int    kind;   // 0: CH_ON, 1: ACK, 2: pulse count, 3: GATED_CYC_CNT
        int    ch;
        int    exp_val;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       cyc = 0;
    int       pulse_cnt [4] = '{default: 0};
    int       checks_total = 0;
    int       checks_pass  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp_val);
        checks_total++;
        if (obs == exp_val) begin
            checks_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_val, cyc);
        end
    endtask

    task automatic sb_push(input int dc, input string tag, input int kind, input int ch, input int exp_val);
        sb_item_t it;
        int       idx;
        it.cyc     = cyc + dc;
        it.tag     = tag;
        it.kind    = kind;
        it.ch      = ch;
        it.exp_val = exp_val;
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].cyc > it.cyc) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, it);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb_q.size() > 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_val("sb_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge CLK);
    endtask

    // Edge counter and gated-pulse counter: a gated output that is high 1ns after a CLK rise
    // means a pulse happened at that edge.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (GATED_CLK[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    // Scoreboard: compare every queued entry whose cycle has arrived.
    always @(negedge CLK) begin
        sb_item_t it;
        int       obs;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            it  = sb_q.pop_front();
            obs = -1;
            case (it.kind)
                0: obs = int'(CH_ON[it.ch]);
                1: obs = int'(ACK[it.ch]);
                2: obs = pulse_cnt[it.ch];
`ifdef CLK_GATE_STAT_EN
                3: obs = int'(GATED_CYC_CNT);
`endif
                default: obs = -1;
            endcase
            check_val(it.tag, obs, it.exp_val);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bases [4];

        IDLE_THR = 4'd3;
        RST      = 1'b0;
        TEST_EN  = 1'b0;
        REQ      = 4'h0;
`ifdef CLK_GATE_STAT_EN
        STAT_CLR = 1'b0;
`endif
        repeat (3) @(negedge CLK);

        // Reset state, sampled in a high phase
        @(posedge CLK);
        #2;
        check_val("rst_gated", int'(GATED_CLK), 0);
        check_val("rst_ch_on", int'(CH_ON), 0);
        check_val("rst_ack", int'(ACK), 0);

        // Wake from the first edge after reset: REQ[0] sampled at edge k+1
        @(negedge CLK);
        RST    = 1'b1;
        REQ[0] = 1'b1;
        sb_push(1, "wake_chon_early", 0, 0, 0);
        sb_push(2, "wake_chon", 0, 0, 1);
        sb_push(2, "wake_no_pulse_yet", 2, 0, pulse_cnt[0]);
        sb_push(3, "wake_first_pulse", 2, 0, pulse_cnt[0] + 1);
        sb_push(3, "wake_ack_early", 1, 0, 0);
        sb_push(4, "wake_ack", 1, 0, 1);
        for (int i = 1; i < 4; i++) begin
            sb_push(4, "wake_other_chon", 0, i, 0);
            sb_push(4, "wake_other_gated", 2, i, pulse_cnt[i]);
        end
        wait_drain(50);

        // Idle timeout: IDLE_THR=3 gives 4 IDLE cycles (pulses at edges j+3..j+6)
        REQ[1] = 1'b1;
        sb_push(5, "idle_pre_ack", 1, 1, 1);
        wait_drain(50);
        REQ[1] = 1'b0;
        base   = pulse_cnt[1];
        sb_push(5, "idle_chon_still", 0, 1, 1);
        sb_push(5, "idle_ack_still", 1, 1, 1);
        sb_push(6, "idle_chon_off", 0, 1, 0);
        sb_push(6, "idle_ack_off", 1, 1, 0);
        sb_push(6, "idle_pulses", 2, 1, base + 6);
        sb_push(9, "idle_pulses_stop", 2, 1, base + 6);
        wait_drain(50);

        // Re-request during the second IDLE cycle: ACK stays high, one pulse per edge
        REQ[2] = 1'b1;
        sb_push(5, "rereq_pre_ack", 1, 2, 1);
        wait_drain(50);
        REQ[2] = 1'b0;
        base   = pulse_cnt[2];
        for (int d = 1; d <= 8; d++) sb_push(d, "rereq_ack", 1, 2, 1);
        sb_push(8, "rereq_chon", 0, 2, 1);
        sb_push(8, "rereq_pulses", 2, 2, base + 8);
        repeat (3) @(negedge CLK);
        REQ[2] = 1'b1;
        wait_drain(50);

        // One-cycle request: WAKE then back to OFF, ACK never rises
        REQ[3] = 1'b1;
        base   = pulse_cnt[3];
        sb_push(1, "abort_chon0", 0, 3, 0);
        sb_push(2, "abort_chon_wake", 0, 3, 1);
        sb_push(2, "abort_ack_wake", 1, 3, 0);
        sb_push(3, "abort_chon_off", 0, 3, 0);
        sb_push(3, "abort_ack_off", 1, 3, 0);
        sb_push(5, "abort_pulses", 2, 3, base + 1);
        @(negedge CLK);
        REQ[3] = 1'b0;
        wait_drain(50);

        // Reset in the high phase with all channels ON
        REQ = 4'hF;
        for (int i = 0; i < 4; i++) sb_push(5, "all_on_ack", 1, i, 1);
        wait_drain(50);
        @(posedge CLK);
        #1;
        check_val("pre_rst_gated", int'(GATED_CLK), 15);
        #1;
        RST = 1'b0;
        #1;
        check_val("midrst_gated", int'(GATED_CLK), 0);
        check_val("midrst_ch_on", int'(CH_ON), 0);
        check_val("midrst_ack", int'(ACK), 0);
        REQ = 4'h0;
        @(negedge CLK);
        RST = 1'b1;

        // Test override from reset-idle: all gated clocks run, CH_ON/ACK stay 0
        @(negedge CLK);
        TEST_EN = 1'b1;
        for (int i = 0; i < 4; i++) bases[i] = pulse_cnt[i];
        for (int i = 0; i < 4; i++) begin
            sb_push(3, "test_pulses", 2, i, bases[i] + 3);
            sb_push(3, "test_chon", 0, i, 0);
            sb_push(3, "test_ack", 1, i, 0);
            sb_push(6, "test_pulses_stop", 2, i, bases[i] + 3);
        end
        repeat (3) @(negedge CLK);
        TEST_EN = 1'b0;
        wait_drain(50);

`ifdef CLK_GATE_STAT_EN
        // Statistics: all channels OFF, so every cycle counts
        STAT_CLR = 1'b1;
        sb_push(1, "stat_clr", 3, 0, 0);
        sb_push(101, "stat_100", 3, 0, 100);
        @(negedge CLK);
        STAT_CLR = 1'b0;
        repeat (100) @(negedge CLK);
        STAT_CLR = 1'b1;
        sb_push(1, "stat_clr2", 3, 0, 0);
        @(negedge CLK);
        STAT_CLR = 1'b0;
        sb_push(65540, "stat_sat", 3, 0, 65535);
        wait_drain(66000);
`endif

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of independently gated clock channels (1..16).
REQ-002 The module SHALL have parameter IDLE_W, default 4, giving the width of the idle-threshold counter.
REQ-003 The module SHALL have parameter WAKE_DLY, default 2, giving the number of enabled cycles before a channel acknowledges a wake request (1..15).
REQ-004 The module SHALL have port CLK, input, 1 bit: the single source clock for all logic and all gated outputs.
REQ-005 The module SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port IDLE_THR, input, IDLE_W bits: idle cycles tolerated before gating, shared by all channels.
REQ-007 The module SHALL have port TEST_EN, input, 1 bit: scan/test override that forces every gated clock to run.
REQ-008 The module SHALL have port REQ, input, NUM_CH bits: per-channel clock request from the consumer.
REQ-009 The module SHALL have port ACK, output, NUM_CH bits: per-channel flag meaning the clock is running and stable.
REQ-010 The module SHALL have port CH_ON, output, NUM_CH bits: per-channel registered clock-enable status.
REQ-011 The module SHALL have port GATED_CLK, output, NUM_CH bits: per-channel gated copies of CLK.

Function
REQ-012 Each channel SHALL run an independent FSM with states OFF, WAKE, ON and IDLE.
REQ-013 In OFF, REQ=1 SHALL move the channel to WAKE and clear its wake counter; otherwise it SHALL stay in OFF.
REQ-014 In WAKE, REQ=0 SHALL return the channel to OFF on the next edge.
REQ-015 In WAKE with REQ=1, the wake counter SHALL increment, and the channel SHALL move to ON when the counter equals WAKE_DLY-1, so that WAKE lasts exactly WAKE_DLY cycles.
REQ-016 In ON, REQ=0 SHALL move the channel to IDLE and clear its idle counter.
REQ-017 In IDLE, REQ=1 SHALL return the channel to ON.
REQ-018 In IDLE with REQ=0, the channel SHALL move to OFF when the idle counter equals IDLE_THR, and SHALL otherwise increment the counter, giving IDLE_THR+1 idle cycles (IDLE_THR=0: one cycle).
REQ-019 CH_ON[i] SHALL be 1 in WAKE, ON and IDLE, and 0 in OFF; it is a registered output with no combinational path from REQ.
REQ-020 ACK[i] SHALL be 1 only in ON and IDLE.
REQ-021 GATED_CLK[i] SHALL equal CLK AND a latch output, where the latch is transparent while CLK=0 and captures (CH_ON[i] OR TEST_EN), so the output is glitch-free with no truncated high phase.
REQ-022 Latency: with REQ sampled high at edge n, CH_ON SHALL rise after edge n+1, the first GATED_CLK rising edge SHALL be n+2, and ACK SHALL rise after edge n+1+WAKE_DLY.
REQ-023 TEST_EN=1 SHALL force all GATED_CLK outputs to run and SHALL NOT alter FSM state, CH_ON or ACK.
REQ-024 A change to IDLE_THR while a channel is in IDLE SHALL take effect on the next compare.

Reset
REQ-025 When RST=0, every FSM SHALL enter OFF, all counters SHALL clear, CH_ON and ACK SHALL be 0, and every latch SHALL clear asynchronously so GATED_CLK is 0 immediately, including when reset arrives mid-WAKE or mid-IDLE.
REQ-026 After RST deasserts, a channel SHALL respond to REQ from the first CLK edge.

Configuration
REQ-027 With macro CLK_GATE_STAT_EN defined, the module SHALL add input STAT_CLR (1 bit) and output GATED_CYC_CNT (16 bits).
REQ-028 GATED_CYC_CNT SHALL count CLK cycles in which at least one channel is OFF, SHALL saturate at 0xFFFF, and SHALL reset to 0.
REQ-029 STAT_CLR=1 SHALL zero GATED_CYC_CNT on the next edge, taking priority over increment.
REQ-030 Without CLK_GATE_STAT_EN, neither the STAT_CLR and GATED_CYC_CNT ports nor the counter logic SHALL exist.

Verification
REQ-031 Wake: defaults, REQ[0] 0->1 at edge 10 -> CH_ON[0]=1 after edge 11, first GATED_CLK[0] edge at 12, ACK[0]=1 after edge 13, and all other channels stay gated.
REQ-032 Idle timeout: IDLE_THR=3, REQ[1] dropped in ON -> exactly 4 further GATED_CLK[1] pulses, then OFF with CH_ON[1]=0 and ACK[1]=0.
REQ-033 Re-request: REQ[2] reasserted during the 2nd IDLE cycle -> back to ON, ACK[2] never drops, and no gated pulse is lost.
REQ-034 Abort and override: REQ[3] pulsed for 1 cycle -> WAKE then OFF with ACK[3]=0; separately, TEST_EN=1 in reset-idle state -> all 4 GATED_CLK toggle while CH_ON=0.
REQ-035 Reset mid-operation: RST=0 mid-high-phase of CLK with channels in ON -> all GATED_CLK=0 within that phase, and all outputs are 0.
REQ-036 Statistics (CLK_GATE_STAT_EN defined): 100 cycles with channel 0 OFF -> GATED_CYC_CNT=100; STAT_CLR pulse -> 0; a forced long run -> holds at 0xFFFF.
